// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache.
// FSM state encoding, tag width derivation and byte merge.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FETCH,
        INSTALL,
        RESPOND
    } state_t;

    function automatic int calc_tag_width(
        input int aw,
        input int iw,
        input int ow
    );
        return aw - iw - ow - 2;
    endfunction

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Replacement choice for one set: lowest invalid way,
// otherwise the set's round-robin pointer.
module cache_victim_select
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 2,
    parameter int WAY_W    = 1
) (
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [WAY_W-1:0]    rr_ptr,
    output logic [WAY_W-1:0]    victim,
    output logic                used_rr
);

    // Scan downwards so the lowest invalid way wins.
    always_comb begin
        victim  = rr_ptr;
        used_rr = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim  = WAY_W'(w);
                used_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate cache
// between one requester and word-wide RAM.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 16,
    parameter int INDEX_WIDTH       = 3,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int NUM_WAYS          = 2,
    parameter int COUNTER_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] cache_address,
    input  logic                     cache_rd,
    input  logic                     cache_wr,
    input  logic [3:0]               cache_byte_enable,
    input  logic [31:0]              cache_data_wr,
    output logic [31:0]              cache_data_out,
    output logic                     cache_ready,
    output logic [COUNTER_WIDTH-1:0] hit_count,
    output logic [COUNTER_WIDTH-1:0] miss_count,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [31:0]              ram_data_wr,
    input  logic [31:0]              ram_data_rd,
    input  logic                     ram_ready
);

    localparam int TAG_WIDTH =
        calc_tag_width(ADDRESS_WIDTH, INDEX_WIDTH, WORD_OFFSET_WIDTH);
    localparam int NUM_SETS       = 2 ** INDEX_WIDTH;
    localparam int WORDS_PER_LINE = 2 ** WORD_OFFSET_WIDTH;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int OW = WORD_OFFSET_WIDTH;

    generate
        if (TAG_WIDTH < 1) begin : g_bad_tag
            $fatal(1, "set_assoc_cache: TAG_WIDTH must be >= 1");
        end
        if (NUM_WAYS != 2 && NUM_WAYS != 4 && NUM_WAYS != 8) begin : g_bad_ways
            $fatal(1, "set_assoc_cache: NUM_WAYS must be 2, 4 or 8");
        end
    endgenerate

    state_t state;

    logic [TAG_WIDTH-1:0]   tag_r;
    logic [INDEX_WIDTH-1:0] index_r;
    logic [OW-1:0]          offset_r;
    logic [31:0]            data_r;
    logic [3:0]             be_r;
    logic                   wr_r;
    logic [WAY_W-1:0]       victim_r;
    logic                   used_rr_r;
    logic [OW-1:0]          word_cnt;
    logic [OW-1:0]          word_nxt;

    logic [TAG_WIDTH-1:0] tag_mem  [NUM_SETS][NUM_WAYS];
    logic [31:0]          data_mem [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
    logic [NUM_WAYS-1:0]  valid    [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty    [NUM_SETS];
    logic [WAY_W-1:0]     rr_ptr   [NUM_SETS];

    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     vs_victim;
    logic                 vs_used_rr;
    logic [TAG_WIDTH-1:0] victim_tag;
    logic [31:0]          victim_word;
    logic [31:0]          victim_word_nxt;
    logic [31:0]          hit_word;
    logic                 last_beat;
    logic                 addr_unused;

    assign addr_unused     = ^cache_address[1:0];
    assign word_nxt        = word_cnt + OW'(1);
    assign last_beat       = (word_cnt == {OW{1'b1}});
    assign victim_tag      = tag_mem[index_r][victim_r];
    assign victim_word     = data_mem[index_r][victim_r][word_cnt];
    assign victim_word_nxt = data_mem[index_r][victim_r][word_nxt];
    assign hit_word        = data_mem[index_r][hit_way][offset_r];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[index_r][w] && tag_mem[index_r][w] == tag_r) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    cache_victim_select #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
    ) u_victim (
        .valid   (valid[index_r]),
        .rr_ptr  (rr_ptr[index_r]),
        .victim  (vs_victim),
        .used_rr (vs_used_rr)
    );

    // Tag/data arrays are never reset; only control state is.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cache_ready    <= 1'b0;
            cache_data_out <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            ram_address    <= '0;
            ram_rd         <= 1'b0;
            ram_wr         <= 1'b0;
            ram_data_wr    <= '0;
            word_cnt       <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s]  <= '0;
                dirty[s]  <= '0;
                rr_ptr[s] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (cache_rd || cache_wr) begin
                        tag_r    <= cache_address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
                        index_r  <= cache_address[2+OW +: INDEX_WIDTH];
                        offset_r <= cache_address[2 +: OW];
                        data_r   <= cache_data_wr;
                        be_r     <= cache_byte_enable;
                        wr_r     <= !cache_rd;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (wr_r) begin
                            data_mem[index_r][hit_way][offset_r] <=
                                merge_bytes(hit_word, data_r, be_r);
                            if (be_r != 4'b0000) begin
                                dirty[index_r][hit_way] <= 1'b1;
                            end
                        end else begin
                            cache_data_out <= hit_word;
                        end
                        if (hit_count != {COUNTER_WIDTH{1'b1}}) begin
                            hit_count <= hit_count + COUNTER_WIDTH'(1);
                        end
                        cache_ready <= 1'b1;
                        state       <= RESPOND;
                    end else begin
                        if (miss_count != {COUNTER_WIDTH{1'b1}}) begin
                            miss_count <= miss_count + COUNTER_WIDTH'(1);
                        end
                        victim_r  <= vs_victim;
                        used_rr_r <= vs_used_rr;
                        word_cnt  <= '0;
                        if (valid[index_r][vs_victim] && dirty[index_r][vs_victim]) begin
                            state <= WRITEBACK;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!ram_wr) begin
                        ram_wr      <= 1'b1;
                        ram_address <= {victim_tag, index_r, word_cnt, 2'b00};
                        ram_data_wr <= victim_word;
                    end else if (ram_ready) begin
                        if (last_beat) begin
                            // Chain straight into the refill so a dirty
                            // miss costs exactly one extra line transfer.
                            ram_wr      <= 1'b0;
                            ram_rd      <= 1'b1;
                            ram_address <= {tag_r, index_r, {OW{1'b0}}, 2'b00};
                            word_cnt    <= '0;
                            state       <= FETCH;
                        end else begin
                            word_cnt    <= word_nxt;
                            ram_address <= {victim_tag, index_r, word_nxt, 2'b00};
                            ram_data_wr <= victim_word_nxt;
                        end
                    end
                end
                FETCH: begin
                    if (!ram_rd) begin
                        ram_rd      <= 1'b1;
                        ram_address <= {tag_r, index_r, word_cnt, 2'b00};
                    end else if (ram_ready) begin
                        data_mem[index_r][victim_r][word_cnt] <= ram_data_rd;
                        if (last_beat) begin
                            ram_rd   <= 1'b0;
                            word_cnt <= '0;
                            state    <= INSTALL;
                        end else begin
                            word_cnt    <= word_nxt;
                            ram_address <= {tag_r, index_r, word_nxt, 2'b00};
                        end
                    end
                end
                INSTALL: begin
                    tag_mem[index_r][victim_r] <= tag_r;
                    valid[index_r][victim_r]   <= 1'b1;
                    dirty[index_r][victim_r]   <= 1'b0;
                    if (used_rr_r) begin
                        rr_ptr[index_r] <= rr_ptr[index_r] + WAY_W'(1);
                    end
                    state <= LOOKUP;
                end
                RESPOND: begin
                    cache_ready <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
